// File: rtl/simple_cpu_core.sv
//------------------------------------------------------------------------------
// simple_cpu_core : 8-bit three-cycle fetch/decode/execute CPU, built-in ROM.
// Optional carry flag, JC and carry_o when SIMPLE_CPU_CARRY_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module simple_cpu_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4,
  parameter bit ROM_OVERRIDE = 1'b0,
  parameter logic [(2**PC_W)*DATA_W-1:0] ROM_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] rega_o,
  output logic [DATA_W-1:0] out_o,
  output logic              out_valid_o,
  output logic              halted_o,
`ifdef SIMPLE_CPU_CARRY_EN
  output logic              carry_o,
`endif
  output logic [1:0]        state_o
);

  localparam logic [1:0] c_st_fetch  = 2'd0;
  localparam logic [1:0] c_st_decode = 2'd1;
  localparam logic [1:0] c_st_exec   = 2'd2;
  localparam logic [1:0] c_st_halt   = 2'd3;

`ifdef SIMPLE_CPU_CARRY_EN
  localparam int c_sw = DATA_W + 1;
`else
  localparam int c_sw = DATA_W;
`endif

  logic [1:0]        r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_ir, r_a, r_b, r_out;
  logic [3:0]        r_opc, r_imm;
  logic              r_z, r_ov;
`ifdef SIMPLE_CPU_CARRY_EN
  logic              r_c, w_c_nxt, w_c_wr;
`endif

  logic              w_do_fetch, w_do_decode, w_do_exec;
  logic [DATA_W-1:0] w_rom, w_imm_ext, w_alu;
  logic [c_sw-1:0]   w_sum, w_diff, w_sumb;
  logic              w_a_wr, w_b_wr, w_jump;

  // Program store: either the fixed default program or a caller-supplied image
  generate
    if (ROM_OVERRIDE) begin : g_rom_init
      assign w_rom = ROM_INIT[r_pc*DATA_W +: DATA_W];
    end else begin : g_rom_table
      always_comb begin
        w_rom = '0;
        case (r_pc)
          PC_W'(0): w_rom = DATA_W'(8'h13);
          PC_W'(1): w_rom = DATA_W'(8'h25);
          PC_W'(2): w_rom = DATA_W'(8'h70);
          PC_W'(3): w_rom = DATA_W'(8'h80);
          PC_W'(4): w_rom = DATA_W'(8'hE0);
          PC_W'(5): w_rom = DATA_W'(8'hF0);
          default:  w_rom = '0;
        endcase
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_fetch;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_fetch:  w_state_nxt = c_st_decode;
      c_st_decode: w_state_nxt = c_st_exec;
      c_st_exec:   w_state_nxt = (r_opc == 4'hF) ? c_st_halt : c_st_fetch;
      default:     w_state_nxt = c_st_halt;
    endcase
  end

  always_comb begin
    w_do_fetch  = 1'b0;
    w_do_decode = 1'b0;
    w_do_exec   = 1'b0;
    halted_o    = 1'b0;
    case (r_state)
      c_st_fetch:  w_do_fetch  = 1'b1;
      c_st_decode: w_do_decode = 1'b1;
      c_st_exec:   w_do_exec   = 1'b1;
      default:     halted_o    = 1'b1;
    endcase
  end

  assign w_imm_ext = DATA_W'(r_imm);
  // One extra MSB (carry build only) captures carry/borrow out of the adders
  assign w_sum  = c_sw'(r_a) + c_sw'(w_imm_ext);
  assign w_diff = c_sw'(r_a) - c_sw'(w_imm_ext);
  assign w_sumb = c_sw'(r_a) + c_sw'(r_b);

  always_comb begin
    w_alu  = r_a;
    w_a_wr = 1'b0;
    w_b_wr = 1'b0;
    w_jump = 1'b0;
`ifdef SIMPLE_CPU_CARRY_EN
    w_c_nxt = r_c;
    w_c_wr  = 1'b0;
`endif
    case (r_opc)
      4'h1: begin w_alu = w_imm_ext;             w_a_wr = 1'b1; end
      4'h2: begin w_alu = w_sum[DATA_W-1:0];     w_a_wr = 1'b1; end
      4'h3: begin w_alu = w_diff[DATA_W-1:0];    w_a_wr = 1'b1; end
      4'h4: begin w_alu = r_a & w_imm_ext;       w_a_wr = 1'b1; end
      4'h5: begin w_alu = r_a | w_imm_ext;       w_a_wr = 1'b1; end
      4'h6: begin w_alu = r_a ^ w_imm_ext;       w_a_wr = 1'b1; end
      4'h7: w_b_wr = 1'b1;
      4'h8: begin w_alu = w_sumb[DATA_W-1:0];    w_a_wr = 1'b1; end
      4'h9: w_jump = 1'b1;
      4'hA: w_jump = r_z;
`ifdef SIMPLE_CPU_CARRY_EN
      4'hB: w_jump = r_c;
`endif
      4'hC: begin w_alu = {r_a[DATA_W-2:0], 1'b0}; w_a_wr = 1'b1; end
      4'hD: begin w_alu = {1'b0, r_a[DATA_W-1:1]}; w_a_wr = 1'b1; end
      default: ;
    endcase
`ifdef SIMPLE_CPU_CARRY_EN
    case (r_opc)
      4'h2: begin w_c_nxt = w_sum[DATA_W];  w_c_wr = 1'b1; end
      4'h3: begin w_c_nxt = w_diff[DATA_W]; w_c_wr = 1'b1; end
      4'h8: begin w_c_nxt = w_sumb[DATA_W]; w_c_wr = 1'b1; end
      4'hC: begin w_c_nxt = r_a[DATA_W-1];  w_c_wr = 1'b1; end
      4'hD: begin w_c_nxt = r_a[0];         w_c_wr = 1'b1; end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_opc <= '0;
      r_imm <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_z   <= 1'b0;
      r_out <= '0;
      r_ov  <= 1'b0;
`ifdef SIMPLE_CPU_CARRY_EN
      r_c   <= 1'b0;
`endif
    end else begin
      r_ov <= 1'b0;
      if (w_do_fetch) begin
        r_ir <= w_rom;
        r_pc <= r_pc + 1'b1;
      end
      if (w_do_decode) begin
        r_opc <= r_ir[DATA_W-1 -: 4];
        r_imm <= r_ir[3:0];
      end
      if (w_do_exec) begin
        // Z tracks exactly the opcodes that rewrite A
        if (w_a_wr) begin
          r_a <= w_alu;
          r_z <= (w_alu == '0);
        end
        if (w_b_wr) r_b <= r_a;
        if (w_jump) r_pc <= PC_W'(r_imm);
        if (r_opc == 4'hE) begin
          r_out <= r_a;
          r_ov  <= 1'b1;
        end
`ifdef SIMPLE_CPU_CARRY_EN
        if (w_c_wr) r_c <= w_c_nxt;
`endif
      end
    end
  end

  assign pc_o        = r_pc;
  assign instr_o     = r_ir;
  assign rega_o      = r_a;
  assign out_o       = r_out;
  assign out_valid_o = r_ov;
  assign state_o     = r_state;
`ifdef SIMPLE_CPU_CARRY_EN
  assign carry_o     = r_c;
`endif

endmodule

`default_nettype wire

// File: tb/tb_simple_cpu_core.sv
//------------------------------------------------------------------------------
// tb_simple_cpu_core : random reset-interval runs of two cores (default ROM and
// a custom image) checked cycle by cycle against an instruction-level model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_simple_cpu_core;

  typedef struct {
    int pc, ir, a, out, ov, hlt, st, c;
  } snap_t;

  localparam logic [127:0] c_prog1 = {8'hA1, 8'hB0, 8'h40, 8'hE0,
                                      8'hF0, 8'h9C, 8'hA0, 8'h80,
                                      8'h70, 8'hD0, 8'hC0, 8'h6A,
                                      8'h53, 8'h4C, 8'h3B, 8'h1A};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] pc0, pc1;
  logic [7:0] ir0, ir1, a0, a1, out0, out1;
  logic ov0, ov1, h0, h1;
  logic [1:0] st0, st1;
  logic c0, c1;

  int checks = 0;
  int failures = 0;
  int rom[2][16];
  snap_t q0[$], q1[$];
  int oq0[$], oq1[$];

  always #5 clk = ~clk;

  simple_cpu_core dut0 (
    .clk(clk), .rst(rst), .pc_o(pc0), .instr_o(ir0), .rega_o(a0),
    .out_o(out0), .out_valid_o(ov0), .halted_o(h0),
`ifdef SIMPLE_CPU_CARRY_EN
    .carry_o(c0),
`endif
    .state_o(st0)
  );

  simple_cpu_core #(.ROM_OVERRIDE(1'b1), .ROM_INIT(c_prog1)) dut1 (
    .clk(clk), .rst(rst), .pc_o(pc1), .instr_o(ir1), .rega_o(a1),
    .out_o(out1), .out_valid_o(ov1), .halted_o(h1),
`ifdef SIMPLE_CPU_CARRY_EN
    .carry_o(c1),
`endif
    .state_o(st1)
  );

`ifndef SIMPLE_CPU_CARRY_EN
  assign c0 = 1'b0;
  assign c1 = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int w, input snap_t s);
    if (w == 0) q0.push_back(s);
    else        q1.push_back(s);
  endtask

  // Instruction-level model: one snapshot per clock edge for k edges after release
  task automatic build(input int w, input int k);
    int pc = 0, ir = 0, a = 0, b = 0, z = 0, cf = 0, out = 0, ov = 0, hlt = 0;
    int e = 0, op, imm, t;
    push(w, '{0, 0, 0, 0, 0, 0, 0, 0});
    while (e < k) begin
      if (hlt != 0) begin
        push(w, '{pc, ir, a, out, 0, 1, 3, cf});
        e++;
        continue;
      end
      ir = rom[w][pc];
      pc = (pc + 1) % 16;
      e++;
      push(w, '{pc, ir, a, out, 0, 0, 1, cf});
      if (e >= k) break;
      e++;
      push(w, '{pc, ir, a, out, 0, 0, 2, cf});
      if (e >= k) break;
      op = ir / 16;
      imm = ir % 16;
      ov = 0;
      case (op)
        1:  a = imm;
        2:  begin t = a + imm; cf = (t > 255) ? 1 : 0; a = t & 255; end
        3:  begin t = a - imm; cf = (t < 0) ? 1 : 0; a = t & 255; end
        4:  a = a & imm;
        5:  a = a | imm;
        6:  a = a ^ imm;
        7:  b = a;
        8:  begin t = a + b; cf = (t > 255) ? 1 : 0; a = t & 255; end
        9:  pc = imm;
        10: if (z != 0) pc = imm;
`ifdef SIMPLE_CPU_CARRY_EN
        11: if (cf != 0) pc = imm;
`endif
        12: begin t = a * 2; cf = (t > 255) ? 1 : 0; a = t & 255; end
        13: begin cf = a % 2; a = a / 2; end
        14: begin
          out = a;
          ov = 1;
          if (w == 0) oq0.push_back(out);
          else        oq1.push_back(out);
        end
        15: hlt = 1;
        default: ;
      endcase
      if (op inside {1, 2, 3, 4, 5, 6, 8, 12, 13}) z = (a == 0) ? 1 : 0;
      e++;
      push(w, '{pc, ir, a, out, ov, hlt, (hlt != 0) ? 3 : 0, cf});
    end
  endtask

  task automatic cmp(input string tg, input snap_t s, input logic [3:0] pc,
                     input logic [7:0] ir, input logic [7:0] a, input logic [7:0] out,
                     input logic ov, input logic h, input logic [1:0] st, input logic c);
    chk({tg, "_pc"},    32'(pc),  s.pc);
    chk({tg, "_instr"}, 32'(ir),  s.ir);
    chk({tg, "_rega"},  32'(a),   s.a);
    chk({tg, "_out"},   32'(out), s.out);
    chk({tg, "_outv"},  32'(ov),  s.ov);
    chk({tg, "_halt"},  32'(h),   s.hlt);
    chk({tg, "_state"}, 32'(st),  s.st);
`ifdef SIMPLE_CPU_CARRY_EN
    chk({tg, "_carry"}, 32'(c),   s.c);
`else
    if (c !== 1'b0) chk({tg, "_carry"}, 32'(c), 0);
`endif
  endtask

  // Monitor: per-cycle snapshot scoreboard plus OUT-pulse scoreboard
  always @(negedge clk) begin
    snap_t s;
    if (q0.size() > 0) begin
      s = q0.pop_front();
      cmp("dut0", s, pc0, ir0, a0, out0, ov0, h0, st0, c0);
    end
    if (q1.size() > 0) begin
      s = q1.pop_front();
      cmp("dut1", s, pc1, ir1, a1, out1, ov1, h1, st1, c1);
    end
    if (ov0 === 1'b1) begin
      if (oq0.size() == 0) chk("dut0_unexpected_out", 32'(out0), 32'hFFFF_FFFF);
      else                 chk("dut0_out_value", 32'(out0), oq0.pop_front());
    end
    if (ov1 === 1'b1) begin
      if (oq1.size() == 0) chk("dut1_unexpected_out", 32'(out1), 32'hFFFF_FFFF);
      else                 chk("dut1_out_value", 32'(out1), oq1.pop_front());
    end
  end

  task automatic reset_checks(input string tg, input logic [3:0] pc, input logic [7:0] ir,
                              input logic [7:0] a, input logic [7:0] out, input logic ov,
                              input logic h, input logic [1:0] st);
    chk({tg, "_rst_pc"},    32'(pc),  0);
    chk({tg, "_rst_instr"}, 32'(ir),  0);
    chk({tg, "_rst_rega"},  32'(a),   0);
    chk({tg, "_rst_out"},   32'(out), 0);
    chk({tg, "_rst_outv"},  32'(ov),  0);
    chk({tg, "_rst_halt"},  32'(h),   0);
    chk({tg, "_rst_state"}, 32'(st),  0);
  endtask

  task automatic run(input int k);
    @(posedge clk);
    #2;
    rst = 1'b1;
    build(0, k);
    build(1, k);
    repeat (k) @(posedge clk);
    @(negedge clk);
    #($urandom_range(1, 3));
    chk("dut0_pending_snapshots", 32'(q0.size()), 0);
    chk("dut1_pending_snapshots", 32'(q1.size()), 0);
    chk("dut0_missing_out", 32'(oq0.size()), 0);
    chk("dut1_missing_out", 32'(oq1.size()), 0);
    q0.delete(); q1.delete(); oq0.delete(); oq1.delete();
    // Asynchronous assertion away from any edge
    rst = 1'b0;
    #1;
    reset_checks("dut0", pc0, ir0, a0, out0, ov0, h0, st0);
    reset_checks("dut1", pc1, ir1, a1, out1, ov1, h1, st1);
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  initial begin
    logic [127:0] p;
    int d[6];
    d = '{8'h13, 8'h25, 8'h70, 8'h80, 8'hE0, 8'hF0};
    p = c_prog1;
    for (int i = 0; i < 16; i++) begin
      rom[0][i] = (i < 6) ? d[i] : 0;
      rom[1][i] = int'(p[i*8 +: 8]);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("dut0", pc0, ir0, a0, out0, ov0, h0, st0);
    run(30);
    run(70);
    for (int r = 0; r < 12; r++) run($urandom_range(1, 60));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/simple_cpu_core.md
Name: simple_cpu_core

Overview:
- Minimal 8-bit multi-cycle CPU with a fetch/decode/execute state machine, a built-in 16-word instruction ROM, accumulator regA, auxiliary regB and a zero flag.
- Each instruction takes exactly 3 clock cycles.
- Standalone top-level core. Internal state is exposed on observation ports for debug and verification.

Parameters:
- DATA_W, 8, width of regA, regB, the output register and each instruction word.
- PC_W, 4, program counter width (16 ROM words; the PC wraps around).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; while 0 all state is held at reset values.
- pc_o  output  PC_W  current program counter.
- instr_o  output  DATA_W  instruction register.
- rega_o  output  DATA_W  accumulator regA.
- out_o  output  DATA_W  output register, written by OUT.
- out_valid_o  output  1  one-cycle pulse in the cycle after OUT executes.
- halted_o  output  1  high once HALT has executed.
- state_o  output  2  FSM state: 0=FETCH, 1=DECODE, 2=EXECUTE, 3=HALT.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - pc=0, instruction=0, regA=0, regB=0, out=0, out_valid=0, Z=0.
  - state=FETCH, halted=0.
  - Reset is honoured in any state, including mid-instruction; the partial instruction is discarded.
- Instruction format: opcode=[7:4], imm=[3:0]; imm is zero-extended to DATA_W.
- FETCH: instruction <= ROM[pc]; pc <= pc+1, wrapping 15->0; next state DECODE.
- DECODE: opcode and imm are latched into decode registers; next state EXECUTE.
- EXECUTE: performs the opcode; next state FETCH, or HALT for opcode F.
- Opcodes (all arithmetic modulo 2^DATA_W):
  - 0 NOP.
  - 1 LDI: A=imm.
  - 2 ADDI: A=A+imm.
  - 3 SUBI: A=A-imm.
  - 4 ANDI: A=A&imm.
  - 5 ORI: A=A|imm.
  - 6 XORI: A=A^imm.
  - 7 MOVBA: B=A.
  - 8 ADDB: A=A+B.
  - 9 JMP: pc=imm.
  - A JZ: pc=imm if Z=1.
  - B JC: see Optional Feature; NOP when the feature is absent.
  - C SHL: A=A<<1.
  - D SHR: A=A>>1 (logical).
  - E OUT: out=A; out_valid_o=1 for exactly the following cycle.
  - F HALT.
- Zero flag Z: updated with (new A==0) on opcodes 1-6, 8, C, D; all other opcodes leave Z unchanged.
- Jumps: a taken jump overrides the increment done in FETCH; a not-taken jump leaves pc at instr+1.
- HALT state: terminal, left only by reset. pc, registers and out are frozen; halted_o=1 from the edge that executes HALT.
- out_valid_o: deasserted in every cycle except the one immediately after the OUT execute edge.
- ROM: combinational case table with the default program below; all other addresses = 0x00 (NOP).
  - 0: 0x13
  - 1: 0x25
  - 2: 0x70
  - 3: 0x80
  - 4: 0xE0
  - 5: 0xF0

Optional Feature:
- Macro SIMPLE_CPU_CARRY_EN.
- Defined:
  - Carry flag C (reset 0) is updated by ADDI/ADDB (carry out of bit DATA_W-1), SUBI (borrow), SHL (bit shifted out of MSB) and SHR (bit shifted out of LSB).
  - Opcode B (JC) jumps to imm if C=1.
  - Extra output port carry_o (1 bit) reflects C.
- Undefined: no carry flag, no carry_o port, opcode B behaves as NOP.

Test Plan:
- Hold rst=0 for 2 cycles, then release -> pc_o=0, instr_o=0, rega_o=0, state_o=0. On the 1st rising edge after release: instr_o=0x13, pc_o=1, state_o=1.
- Default program from reset -> after edge 3: rega_o=3. Edge 6: rega_o=8. Edge 9: regB=8. Edge 12: rega_o=0x10.
- OUT instruction -> edge 15: out_o=0x10 and out_valid_o high for exactly one cycle.
- HALT -> edge 18: halted_o=1, state_o=3, pc_o=6; values unchanged 10 cycles later.
- Assert rst=0 asynchronously mid-EXECUTE -> all outputs return to reset values immediately without a clock edge. After release, execution restarts from pc=0.
- ROM overridden with 0x10, 0xA3 (JZ 3), 0x15, 0xF0 at address 3 -> Z=1, pc jumps to 3, HALT with rega_o=0. With SIMPLE_CPU_CARRY_EN, a program 0x1F, 0xC0 ×4, 0x21 then ADDI overflow -> carry_o=1.
